fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor for configurable exponent and mantissa widths.
- Adds round-to-nearest-even, special-value handling, exception flags, per-op subtract mode, an opaque tag and valid/ready backpressure.
- Sits in the datapath library beside the other fp arithmetic units.
- Feeds accumulators and dot-product engines that need stalls and in-order tagged results.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored fraction width, implicit bit excluded (>=4)
TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  reset
in_vld  in  1  operation valid
in_rdy  out  1  block can accept an operation this cycle
in_sub  in  1  1 = compute a - b; 0 = a + b
in_tag  in  TAG_W  opaque tag, returned with result
a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
b  in  1+EXP_W+MAN_W  operand B
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts result
out_tag  out  TAG_W  tag of result
sum  out  1+EXP_W+MAN_W  result
flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is clk.
- Reset values: out_vld=0, sum=0, flags=0, out_tag=0. All pipeline valid bits clear. Datapath registers need no reset.
- Latency and throughput:
  - Fixed 6 cycles from accepted input (in_vld && in_rdy) to out_vld, while not stalled.
  - Throughput is 1 op/cycle.
- Stall:
  - stall = out_vld && !out_rdy; in_rdy = !stall.
  - A stall freezes every stage, including valid bits.
  - Results are never dropped or reordered. sum, flags and out_tag stay stable while out_vld && !out_rdy.
- Stages:
  - S1: unpack; effective sign of b = b.sign ^ in_sub; classify zero/inf/NaN; detect denormals; swap so the larger magnitude (exp, then frac) is operand X; exp_diff.
  - S2: align Y by exp_diff into MAN_W+4 bits (implicit, frac, guard, round). All shifted-out bits OR into sticky. exp_diff >= MAN_W+3 leaves Y = sticky only.
  - S3: effective add/sub of magnitudes. X >= Y, so the result is never negative. Result sign = X sign.
  - S4: leading-zero count via fp_lzc; normalise left (or right by 1 on carry-out, folding the lost bit into sticky); adjust exponent.
  - S5: round-to-nearest-even on guard/round/sticky. A mantissa carry increments the exponent.
  - S6: apply overflow/underflow/special overrides; register outputs.
- Width rules:
  - Internal exponent is EXP_W+2 bits, signed, so under- and overflow are detectable before clamping.
  - bias = 2^(EXP_W-1)-1.
- Denormals: exp==0 inputs are flushed to signed zero with no flag. Results below the minimum normal flush to signed zero with underflow=1 and inexact=1.
- Overflow: biased exp >= all-ones after rounding gives signed infinity, overflow=1, inexact=1.
- Special cases:
  - Any NaN input gives the canonical qNaN {0, all-ones, 1, zeros}. invalid=1 if any input is a signalling NaN (frac MSB=0).
  - inf + (-inf) effective gives canonical qNaN, invalid=1.
  - inf with a finite operand gives that inf.
  - Exact-zero result is +0, except (-0)+(-0) effective, which gives -0.
- inexact: set whenever guard|round|sticky is nonzero at rounding.
- Reset mid-operation: every in-flight op is discarded, out_vld drops the cycle after rst.

Decomposition:
- Package fp_pkg holds:
  - the flag struct (invalid, overflow, underflow, inexact);
  - the function fp_bias(EXP_W);
  - the function fp_qnan(EXP_W, MAN_W);
  - the constant FP_ADD_LAT = 6;
  - the operand class enum (ZERO, NORM, INF, QNAN, SNAN).
- One sub-module, fp_lzc: parametrised priority leading-zero counter, width W, outputs count and all_zero. It is combinational and instantiated in S4.

Test Plan (binary32 defaults):
- 1.0 + 2.0 (0x3F800000, 0x40000000, in_sub=0) -> sum=0x40400000, flags=0, out_vld exactly 6 cycles later, tag echoed.
- 0x3F800001 + 0x33800000 (exact half-ulp tie) -> 0x3F800002 (round to even), inexact=1. 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1.
- 1.5 - 1.5 (0x3FC00000 both, in_sub=1) -> 0x00000000. -0 + -0 (0x80000000 both) -> 0x80000000.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1. 0x00800000 - 0x00800001 -> 0x80000000, underflow=1.
- +inf + -inf (0x7F800000, 0xFF800000) -> 0x7FC00000, invalid=1. 0x7F800001 + 1.0 -> 0x7FC00000, invalid=1.
- Stream 20 back-to-back ops with tags 0..15 wrapping while toggling out_rdy randomly -> all 20 results in order, outputs held stable during stall, in_rdy low only while stalled; rst asserted mid-stream -> out_vld=0 next cycle, no stale results afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the fp arithmetic units.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

    // Pipeline depth of fp_addsub_pipe, from accepted input to out_vld.
    localparam int FP_ADD_LAT = 6;

    // Exception flags in port order {invalid, overflow, underflow, inexact}.
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Operand classes. Denormal encodings classify as ZERO because they are flushed.
    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_t;

    // Special-case outcome decided at unpack and applied at the output stage.
    typedef struct packed {
        logic nan;        // result is the canonical qNaN
        logic invalid;    // signalling NaN input or inf - inf
        logic inf;        // result is an infinity taken from an input
        logic inf_sign;   // sign of that infinity
        logic neg_zero;   // (-0) + (-0): an exact zero keeps the negative sign
    } fp_spec_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in a wide word.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Priority leading-zero counter: number of zeros above the highest set bit.
// Latency: combinational.
// Backpressure: none. Ports: data in; count out (W when all zero); all_zero out.
module fp_lzc #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Scanning upward lets the highest set bit make the last assignment.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = ~|data;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract with round-to-nearest-even, specials and flags.
// Latency: 6 cycles from in_vld && in_rdy to out_vld; 1 op/cycle.
// Backpressure: out_vld && !out_rdy freezes every stage and drops in_rdy; nothing is lost.
// Ports: clk/rst (sync, active-high); in_vld/in_rdy/in_sub/in_tag/a/b operation in;
//        out_vld/out_rdy/out_tag/sum/flags {invalid, overflow, underflow, inexact} result out.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic                     in_sub,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [TAG_W-1:0]         out_tag,
    output logic [EXP_W+MAN_W:0]     sum,
    output logic [3:0]               flags
);

    localparam int FW  = 1 + EXP_W + MAN_W;  // packed operand width
    localparam int MGW = EXP_W + MAN_W;      // magnitude {exp, frac}
    localparam int ALN = MAN_W + 3;          // implicit, frac, guard, round
    localparam int AW  = MAN_W + 4;          // ALN plus sticky
    localparam int SW  = MAN_W + 5;          // AW plus carry-out
    localparam int XW  = EXP_W + 2;          // signed internal exponent
    localparam int CW  = $clog2(AW + 1);

    localparam logic [127:0]          QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [FW-1:0]         QNAN_VAL  = QNAN_WIDE[FW-1:0];
    localparam logic signed [XW-1:0]  EXP_ONES  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0]  EXP_ZERO  = '0;

    // ---------------------------------------------------------------- control
    logic [FP_ADD_LAT-1:0] vld_q;
    logic                  stall;
    logic                  adv;

    assign out_vld = vld_q[FP_ADD_LAT-1];
    assign stall   = out_vld & ~out_rdy;
    assign in_rdy  = ~stall;
    assign adv     = ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[FP_ADD_LAT-2:0], in_vld};
        end
    end

    // ---------------------------------------------------------------- S1 unpack
    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return ZERO;
        end
        if (&e) begin
            if (f == '0) begin
                return INF;
            end
            return f[MAN_W-1] ? QNAN : SNAN;
        end
        return NORM;
    endfunction

    logic             sa, sb;
    fp_class_t        ca, cb;
    logic [MGW-1:0]   mag_a, mag_b, mag_x, mag_y;
    logic             a_ge_b, zx, zy;
    logic             sx_c, sy_c;
    logic [EXP_W-1:0] ex_c, ey_c;
    fp_spec_t         spec_c;
    logic             nan_in, inf_cancel;

    always_comb begin
        sa = a[FW-1];
        sb = b[FW-1] ^ in_sub;
        ca = classify(a[FW-2:MAN_W], a[MAN_W-1:0]);
        cb = classify(b[FW-2:MAN_W], b[MAN_W-1:0]);
        // Flushed operands compare as exact zero.
        mag_a  = (ca == ZERO) ? '0 : a[MGW-1:0];
        mag_b  = (cb == ZERO) ? '0 : b[MGW-1:0];
        a_ge_b = (mag_a >= mag_b);
        mag_x  = a_ge_b ? mag_a : mag_b;
        mag_y  = a_ge_b ? mag_b : mag_a;
        sx_c   = a_ge_b ? sa : sb;
        sy_c   = a_ge_b ? sb : sa;
        zx     = a_ge_b ? (ca == ZERO) : (cb == ZERO);
        zy     = a_ge_b ? (cb == ZERO) : (ca == ZERO);
        ex_c   = mag_x[MGW-1:MAN_W];
        ey_c   = mag_y[MGW-1:MAN_W];

        nan_in     = (ca == QNAN) || (ca == SNAN) || (cb == QNAN) || (cb == SNAN);
        inf_cancel = (ca == INF) && (cb == INF) && (sa != sb);
        spec_c.nan      = nan_in || inf_cancel;
        spec_c.invalid  = (ca == SNAN) || (cb == SNAN) || inf_cancel;
        spec_c.inf      = (ca == INF) || (cb == INF);
        spec_c.inf_sign = (ca == INF) ? sa : sb;
        spec_c.neg_zero = (ca == ZERO) && (cb == ZERO) && sa && sb;
    end

    logic [TAG_W-1:0] s1_tag;
    logic             s1_sx, s1_esub;
    logic [EXP_W-1:0] s1_ex, s1_diff;
    logic [MAN_W:0]   s1_mx, s1_my;
    fp_spec_t         s1_spec;

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag  <= in_tag;
            s1_sx   <= sx_c;
            s1_esub <= sx_c ^ sy_c;
            s1_ex   <= ex_c;
            s1_diff <= ex_c - ey_c;
            s1_mx   <= {~zx, mag_x[MAN_W-1:0]};
            s1_my   <= {~zy, mag_y[MAN_W-1:0]};
            s1_spec <= spec_c;
        end
    end

    // ---------------------------------------------------------------- S2 align
    logic [2*ALN-1:0] ext;
    logic [AW-1:0]    y_al;

    always_comb begin
        ext  = '0;
        y_al = '0;
        if (int'(s1_diff) >= ALN) begin
            // Everything shifts out; only the sticky survives.
            y_al = {{ALN{1'b0}}, |s1_my};
        end else begin
            ext  = {s1_my, 2'b00, {ALN{1'b0}}} >> s1_diff;
            y_al = {ext[2*ALN-1:ALN], |ext[ALN-1:0]};
        end
    end

    logic [TAG_W-1:0] s2_tag;
    logic             s2_sx, s2_esub;
    logic [EXP_W-1:0] s2_ex;
    logic [AW-1:0]    s2_x, s2_y;
    fp_spec_t         s2_spec;

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_tag  <= s1_tag;
            s2_sx   <= s1_sx;
            s2_esub <= s1_esub;
            s2_ex   <= s1_ex;
            s2_x    <= {s1_mx, 3'b000};
            s2_y    <= y_al;
            s2_spec <= s1_spec;
        end
    end

    // ---------------------------------------------------------------- S3 add/sub
    // X >= Y in magnitude, so the difference never goes negative.
    logic [SW-1:0] r_c;
    assign r_c = s2_esub ? ({1'b0, s2_x} - {1'b0, s2_y}) : ({1'b0, s2_x} + {1'b0, s2_y});

    logic [TAG_W-1:0] s3_tag;
    logic             s3_sx;
    logic [EXP_W-1:0] s3_ex;
    logic [SW-1:0]    s3_r;
    fp_spec_t         s3_spec;

    always_ff @(posedge clk) begin
        if (adv) begin
            s3_tag  <= s2_tag;
            s3_sx   <= s2_sx;
            s3_ex   <= s2_ex;
            s3_r    <= r_c;
            s3_spec <= s2_spec;
        end
    end

    // ---------------------------------------------------------------- S4 normalise
    logic [CW-1:0]          lz;
    logic                   lz_zero;
    logic [AW-1:0]          n_c;
    logic signed [XW-1:0]   e_base, lz_x, e4_c;
    logic                   zero_c;

    fp_lzc #(
        .W  (AW),
        .CW (CW)
    ) u_lzc (
        .data     (s3_r[AW-1:0]),
        .count    (lz),
        .all_zero (lz_zero)
    );

    always_comb begin
        e_base = {2'b00, s3_ex};
        lz_x   = XW'(lz);
        zero_c = ~s3_r[SW-1] & lz_zero;
        if (s3_r[SW-1]) begin
            // Carry-out: shift right one, the dropped bit joins the sticky.
            n_c  = {s3_r[SW-1:2], s3_r[1] | s3_r[0]};
            e4_c = e_base + XW'(1);
        end else begin
            n_c  = s3_r[AW-1:0] << lz;
            e4_c = e_base - lz_x;
        end
    end

    logic [TAG_W-1:0]     s4_tag;
    logic                 s4_sx, s4_zero;
    logic signed [XW-1:0] s4_e;
    logic [AW-1:0]        s4_n;
    fp_spec_t             s4_spec;

    always_ff @(posedge clk) begin
        if (adv) begin
            s4_tag  <= s3_tag;
            s4_sx   <= s3_sx;
            s4_zero <= zero_c;
            s4_e    <= e4_c;
            s4_n    <= n_c;
            s4_spec <= s3_spec;
        end
    end

    // ---------------------------------------------------------------- S5 round
    // s4_n = {implicit, frac[MAN_W], guard, round, sticky}
    logic                 rnd_up;
    logic [MAN_W+1:0]     m_c;
    logic [MAN_W-1:0]     frac_c;
    logic signed [XW-1:0] e5_c;

    always_comb begin
        rnd_up = s4_n[2] & (s4_n[1] | s4_n[0] | s4_n[3]);
        m_c    = {1'b0, s4_n[AW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        // A rounding carry gives 10.000..., so the fraction is the upper bits shifted.
        frac_c = m_c[MAN_W+1] ? m_c[MAN_W:1] : m_c[MAN_W-1:0];
        e5_c   = s4_e + {{(XW-1){1'b0}}, m_c[MAN_W+1]};
    end

    logic [TAG_W-1:0]     s5_tag;
    logic                 s5_sx, s5_zero, s5_inexact;
    logic signed [XW-1:0] s5_e;
    logic [MAN_W-1:0]     s5_frac;
    fp_spec_t             s5_spec;

    always_ff @(posedge clk) begin
        if (adv) begin
            s5_tag     <= s4_tag;
            s5_sx      <= s4_sx;
            s5_zero    <= s4_zero;
            s5_inexact <= |s4_n[2:0];
            s5_e       <= e5_c;
            s5_frac    <= frac_c;
            s5_spec    <= s4_spec;
        end
    end

    // ---------------------------------------------------------------- S6 overrides
    logic [FW-1:0] res_c;
    fp_flags_t     fl_c;

    always_comb begin
        res_c          = {s5_sx, s5_e[EXP_W-1:0], s5_frac};
        fl_c           = '0;
        fl_c.inexact   = s5_inexact;
        if (s5_spec.nan) begin
            res_c        = QNAN_VAL;
            fl_c         = '0;
            fl_c.invalid = s5_spec.invalid;
        end else if (s5_spec.inf) begin
            res_c = {s5_spec.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl_c  = '0;
        end else if (s5_zero) begin
            res_c = {s5_spec.neg_zero, {(FW-1){1'b0}}};
            fl_c  = '0;
        end else if (s5_e >= EXP_ONES) begin
            res_c          = {s5_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl_c.overflow  = 1'b1;
            fl_c.inexact   = 1'b1;
        end else if (s5_e <= EXP_ZERO) begin
            res_c          = {s5_sx, {(FW-1){1'b0}}};
            fl_c.underflow = 1'b1;
            fl_c.inexact   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            flags   <= '0;
            out_tag <= '0;
        end else if (adv && vld_q[FP_ADD_LAT-2]) begin
            sum     <= res_c;
            flags   <= fl_c;
            out_tag <= s5_tag;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
module tb_fp_addsub_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        in_sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [3:0]  out_tag;
    logic [31:0] sum;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe #(
        .EXP_W (8),
        .MAN_W (23),
        .TAG_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_sub  (in_sub),
        .in_tag  (in_tag),
        .a       (a),
        .b       (b),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_tag (out_tag),
        .sum     (sum),
        .flags   (flags)
    );

    // Issue one op into an idle pipe and wait (bounded) for its result.
    // lat = cycles from the driving cycle to out_vld, or -1 on timeout.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic [3:0] itag, output logic [31:0] r, output logic [3:0] f,
                         output logic [3:0] t, output int lat);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b1; a = ia; b = ib; in_sub = isub; in_tag = itag;
        @(posedge clk); #1;
        in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = sum; f = flags; t = out_tag;
        if (!out_vld) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h want 00000000", sum); end
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0000", flags); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        rst = 1'b0;
    endtask

    // Generic vector runner body repeated per feature so each task owns its checks.
    task automatic test_basic;
        logic [31:0] va [3], vb [3], ve [3];
        logic        vs [3];
        logic [3:0]  vf [3];
        logic [31:0] r; logic [3:0] f, t; int lat;
        // 1+2=3; 1-2=-1; denormal+1 flushes to 1.0 without flags
        va = '{32'h3F800000, 32'h3F800000, 32'h00000001};
        vb = '{32'h40000000, 32'h40000000, 32'h3F800000};
        vs = '{1'b0, 1'b1, 1'b0};
        ve = '{32'h40400000, 32'hBF800000, 32'h3F800000};
        vf = '{4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vs[i], 4'(10 + i), r, f, t, lat);
            total++; if (lat != 6) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want 6", i, lat); end
            total++; if (r !== ve[i]) begin bad++; $display("FAIL basic_sum[%0d]: got %h want %h", i, r, ve[i]); end
            total++; if (f !== vf[i]) begin bad++; $display("FAIL basic_flags[%0d]: got %b want %b", i, f, vf[i]); end
            total++; if (t !== 4'(10 + i)) begin bad++; $display("FAIL basic_tag[%0d]: got %h want %h", i, t, 4'(10 + i)); end
        end
    endtask

    task automatic test_rounding;
        logic [31:0] va [2], vb [2], ve [2];
        logic [31:0] r; logic [3:0] f, t; int lat;
        // exact half-ulp ties: odd lsb rounds up to even, even lsb stays
        va = '{32'h3F800001, 32'h3F800000};
        vb = '{32'h33800000, 32'h33800000};
        ve = '{32'h3F800002, 32'h3F800000};
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], 1'b0, 4'(i), r, f, t, lat);
            total++; if (lat != 6) begin bad++; $display("FAIL round_latency[%0d]: got %0d want 6", i, lat); end
            total++; if (r !== ve[i]) begin bad++; $display("FAIL round_sum[%0d]: got %h want %h", i, r, ve[i]); end
            total++; if (f !== 4'b0001) begin bad++; $display("FAIL round_flags[%0d]: got %b want 0001", i, f); end
        end
    endtask

    task automatic test_zero;
        logic [31:0] va [3], vb [3], ve [3];
        logic        vs [3];
        logic [31:0] r; logic [3:0] f, t; int lat;
        // 1.5-1.5=+0; (-0)+(-0)=-0; (-0)+(+0)=+0
        va = '{32'h3FC00000, 32'h80000000, 32'h80000000};
        vb = '{32'h3FC00000, 32'h80000000, 32'h00000000};
        vs = '{1'b1, 1'b0, 1'b0};
        ve = '{32'h00000000, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vs[i], 4'(3 + i), r, f, t, lat);
            total++; if (lat != 6) begin bad++; $display("FAIL zero_latency[%0d]: got %0d want 6", i, lat); end
            total++; if (r !== ve[i]) begin bad++; $display("FAIL zero_sum[%0d]: got %h want %h", i, r, ve[i]); end
            total++; if (f !== 4'b0000) begin bad++; $display("FAIL zero_flags[%0d]: got %b want 0000", i, f); end
        end
    endtask

    task automatic test_range;
        logic [31:0] va [2], vb [2], ve [2];
        logic        vs [2];
        logic [3:0]  vf [2];
        logic [31:0] r; logic [3:0] f, t; int lat;
        // max+max overflows to +inf; 0x00800000-0x00800001 falls below min normal
        va = '{32'h7F7FFFFF, 32'h00800000};
        vb = '{32'h7F7FFFFF, 32'h00800001};
        vs = '{1'b0, 1'b1};
        ve = '{32'h7F800000, 32'h80000000};
        vf = '{4'b0101, 4'b0011};
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], vs[i], 4'(7 + i), r, f, t, lat);
            total++; if (lat != 6) begin bad++; $display("FAIL range_latency[%0d]: got %0d want 6", i, lat); end
            total++; if (r !== ve[i]) begin bad++; $display("FAIL range_sum[%0d]: got %h want %h", i, r, ve[i]); end
            total++; if (f !== vf[i]) begin bad++; $display("FAIL range_flags[%0d]: got %b want %b", i, f, vf[i]); end
        end
    endtask

    task automatic test_special;
        logic [31:0] va [4], vb [4], ve [4];
        logic [3:0]  vf [4];
        logic [31:0] r; logic [3:0] f, t; int lat;
        // inf-inf; sNaN+1; qNaN+1; inf+1
        va = '{32'h7F800000, 32'h7F800001, 32'h7FC00000, 32'h7F800000};
        vb = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        ve = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000};
        vf = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, 4'(12 + i), r, f, t, lat);
            total++; if (lat != 6) begin bad++; $display("FAIL special_latency[%0d]: got %0d want 6", i, lat); end
            total++; if (r !== ve[i]) begin bad++; $display("FAIL special_sum[%0d]: got %h want %h", i, r, ve[i]); end
            total++; if (f !== vf[i]) begin bad++; $display("FAIL special_flags[%0d]: got %b want %b", i, f, vf[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ea [20], eb [20], es [20];
        logic        sb [20];
        logic [31:0] hold_sum; logic [3:0] hold_fl, hold_tag;
        logic        held;
        int tx, rx, cyc, stalls;
        // x+0 = x; x-x = +0; x+x = x with exponent one higher (all exact)
        for (int i = 0; i < 20; i++) begin
            ea[i] = 32'h3F800000 | (32'(i) << 4);
            case (i % 3)
                0:       begin eb[i] = 32'h0;  sb[i] = 1'b0; es[i] = ea[i]; end
                1:       begin eb[i] = ea[i];  sb[i] = 1'b1; es[i] = 32'h0; end
                default: begin eb[i] = ea[i];  sb[i] = 1'b0; es[i] = ea[i] + 32'h00800000; end
            endcase
        end
        tx = 0; rx = 0; cyc = 0; held = 1'b0; stalls = 0;
        hold_sum = '0; hold_fl = '0; hold_tag = '0;
        @(posedge clk); #1;
        in_vld = 1'b1; a = ea[0]; b = eb[0]; in_sub = sb[0]; in_tag = 4'h0; out_rdy = 1'b1;
        while (rx < 20 && cyc < 400) begin
            @(negedge clk);
            total++;
            if (in_rdy !== !(out_vld && !out_rdy)) begin
                bad++; $display("FAIL stream_in_rdy: got %b with out_vld=%b out_rdy=%b", in_rdy, out_vld, out_rdy);
            end
            if (held) begin
                total++;
                if (out_vld !== 1'b1 || sum !== hold_sum || flags !== hold_fl || out_tag !== hold_tag) begin
                    bad++; $display("FAIL stream_hold: got vld=%b %h/%b/%h want 1 %h/%b/%h",
                                    out_vld, sum, flags, out_tag, hold_sum, hold_fl, hold_tag);
                end
            end
            held = out_vld && !out_rdy;
            if (held) begin
                stalls++; hold_sum = sum; hold_fl = flags; hold_tag = out_tag;
            end
            if (out_vld && out_rdy) begin
                total++;
                if (sum !== es[rx] || flags !== 4'h0 || out_tag !== 4'(rx % 16)) begin
                    bad++; $display("FAIL stream_result[%0d]: got %h/%b/%h want %h/0000/%h",
                                    rx, sum, flags, out_tag, es[rx], 4'(rx % 16));
                end
                rx++;
            end
            if (in_vld && in_rdy) tx++;
            @(posedge clk); #1;
            cyc++;
            if (tx < 20) begin
                in_vld = 1'b1; a = ea[tx]; b = eb[tx]; in_sub = sb[tx]; in_tag = 4'(tx % 16);
            end else begin
                in_vld = 1'b0;
            end
            out_rdy = ($urandom_range(0, 3) != 0);
        end
        total++; if (rx != 20) begin bad++; $display("FAIL stream_count: got %0d want 20", rx); end
        total++; if (stalls == 0) begin bad++; $display("FAIL stream_stalls: got 0 want >0"); end
        in_vld = 1'b0; out_rdy = 1'b1;
    endtask

    task automatic test_reset_midstream;
        int seen;
        logic [31:0] r; logic [3:0] f, t; int lat;
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_vld = 1'b1; a = 32'h3F800000; b = 32'h40000000; in_sub = 1'b0; in_tag = 4'(i);
        end
        @(posedge clk); #1;
        total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b want 1", out_vld); end
        rst = 1'b1; in_vld = 1'b0;
        @(posedge clk); #1;
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %b want 0", out_vld); end
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_vld) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_stale: got %0d want 0", seen); end
        do_op(32'h3F800000, 32'h40000000, 1'b0, 4'h9, r, f, t, lat);
        total++; if (lat != 6 || r !== 32'h40400000 || t !== 4'h9) begin
            bad++; $display("FAIL midrst_recover: got lat=%0d %h tag %h want 6 40400000 9", lat, r, t);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_zero();
        test_range();
        test_special();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
